// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 16-bit pipelined CPU. Owns the program
// counter, presents it to instruction_mem (which answers combinationally in
// the same cycle) and captures the returned word together with its PC+1 into
// the IF/ID pipeline register. A taken branch resolved in decode redirects
// the PC and squashes the word currently being fetched; a hazard stall freezes
// the PC and the IF/ID register.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   pc_out       current fetch address (registered) to instruction_mem
//   instr_in     word returned by instruction_mem for pc_out, same cycle
//   stall        hazard unit request: hold PC and IF/ID
//   br_taken     decode resolved a taken branch this cycle (beats stall)
//   br_base_pc   PC+1 of the branch instruction
//   br_offset    signed branch offset field
//   if_id_instr  registered instruction to decode
//   if_id_pc1    registered PC+1 of if_id_instr
//   if_id_valid  1 = real instruction, 0 = bubble
//   fetch_count  number of instructions accepted into IF/ID (debug, wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter int                     OFF_WIDTH   = 6,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = 16'h0000,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    pc_out,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   stall,
    input  logic                   br_taken,
    input  logic [PC_WIDTH-1:0]    br_base_pc,
    input  logic [OFF_WIDTH-1:0]   br_offset,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc1,
    output logic                   if_id_valid,
    output logic [15:0]            fetch_count
);

    localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};

    // Two's-complement sign extension of the branch offset to PC width.
    function automatic logic [PC_WIDTH-1:0] sext_offset(input logic [OFF_WIDTH-1:0] off);
        sext_offset = {{(PC_WIDTH-OFF_WIDTH){off[OFF_WIDTH-1]}}, off};
    endfunction

    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_plus1;
    logic [PC_WIDTH-1:0]    br_target;

    logic [PC_WIDTH-1:0]    pc_next;
    logic [INSTR_WIDTH-1:0] instr_next;
    logic [PC_WIDTH-1:0]    pc1_next;
    logic                   valid_next;
    logic [15:0]            count_next;

    // Incremented PC and branch target; both wrap silently modulo 2^PC_WIDTH.
    always_comb begin
        pc_plus1  = pc + PC_ONE;
        br_target = br_base_pc + sext_offset(br_offset);
    end

    // Next-state selection: branch beats stall, stall beats advance.
    always_comb begin
        pc_next    = pc;
        instr_next = if_id_instr;
        pc1_next   = if_id_pc1;
        valid_next = if_id_valid;
        count_next = fetch_count;
        if (br_taken) begin
            // Redirect and squash the word sitting at pc_out this cycle.
            pc_next    = br_target;
            instr_next = NOP_WORD;
            pc1_next   = PC_ZERO;
            valid_next = 1'b0;
        end else if (stall) begin
            // Hold everything; the same pc_out is re-read next cycle.
            pc_next    = pc;
            instr_next = if_id_instr;
            pc1_next   = if_id_pc1;
            valid_next = if_id_valid;
        end else begin
            pc_next    = pc_plus1;
            instr_next = instr_in;
            pc1_next   = pc_plus1;
            valid_next = 1'b1;
            count_next = fetch_count + 16'd1;
        end
    end

    // PC and IF/ID pipeline register, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_WORD;
            if_id_pc1   <= PC_ZERO;
            if_id_valid <= 1'b0;
            fetch_count <= 16'd0;
        end else begin
            pc          <= pc_next;
            if_id_instr <= instr_next;
            if_id_pc1   <= pc1_next;
            if_id_valid <= valid_next;
            fetch_count <= count_next;
        end
    end

    // pc_out is a pure register output: no path from stall/br_* to it.
    assign pc_out = pc;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. instruction_mem is modelled as
// instr_in = 16'h9000 + pc_out. A reference model of the fetch stage computes
// the expected post-edge state for every applied cycle and pushes it to a
// scoreboard queue; after the edge the entry is popped and compared. Each
// scenario task also checks the concrete values derived by hand.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [15:0] pc_out;
    logic [15:0] instr_in;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_base_pc;
    logic [5:0]  br_offset;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc1;
    logic        if_id_valid;
    logic [15:0] fetch_count;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pc1;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    int vectors;
    int miscompares;

    // reference model state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pc1;
    logic        m_valid;
    logic [15:0] m_cnt;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_out      (pc_out),
        .instr_in    (instr_in),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_base_pc  (br_base_pc),
        .br_offset   (br_offset),
        .if_id_instr (if_id_instr),
        .if_id_pc1   (if_id_pc1),
        .if_id_valid (if_id_valid),
        .fetch_count (fetch_count)
    );

    // instruction memory model: combinational, same-cycle read
    assign instr_in = 16'h9000 + pc_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, predict the result, push it, clock, then
    // pop the prediction and compare it with the DUT.
    task automatic apply_and_score(input logic s, input logic b,
                                   input logic [15:0] base, input logic [5:0] off);
        exp_t e;
        exp_t got;
        stall      = s;
        br_taken   = b;
        br_base_pc = base;
        br_offset  = off;
        if (b) begin
            m_pc    = base + {{10{off[5]}}, off};
            m_instr = 16'h0000;
            m_pc1   = 16'h0000;
            m_valid = 1'b0;
        end else if (!s) begin
            m_instr = 16'h9000 + m_pc;
            m_pc    = m_pc + 16'd1;
            m_pc1   = m_pc;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 16'd1;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc1 = m_pc1; e.valid = m_valid; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        stall    = 1'b0;
        br_taken = 1'b0;
        if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            e = sb.pop_front();
            got.pc = pc_out; got.instr = if_id_instr; got.pc1 = if_id_pc1;
            got.valid = if_id_valid; got.cnt = fetch_count;
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL sb_state: got pc=%h instr=%h pc1=%h valid=%b cnt=%h required pc=%h instr=%h pc1=%h valid=%b cnt=%h",
                         got.pc, got.instr, got.pc1, got.valid, got.cnt,
                         e.pc, e.instr, e.pc1, e.valid, e.cnt);
            end
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pc1 = 16'h0000;
        m_valid = 1'b0; m_cnt = 16'h0000;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if ({pc_out, if_id_instr, if_id_pc1, if_id_valid, fetch_count} !== {16'h0, 16'h0, 16'h0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_state: got pc=%h instr=%h pc1=%h valid=%b cnt=%h required all zero",
                     pc_out, if_id_instr, if_id_pc1, if_id_valid, fetch_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
        vectors++;
        if ({pc_out, if_id_instr, if_id_pc1, if_id_valid} !== {16'd1, 16'h9000, 16'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL first_fetch: got pc=%h instr=%h pc1=%h valid=%b required 0001 9000 0001 1",
                     pc_out, if_id_instr, if_id_pc1, if_id_valid);
        end
        apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
        apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
        vectors++;
        if (pc_out !== 16'd3 || fetch_count !== 16'd3) begin
            miscompares++;
            $display("FAIL free_run_3: got pc=%h cnt=%h required 0003 0003", pc_out, fetch_count);
        end
    endtask

    task automatic test_stall();
        apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
        apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
        for (int i = 0; i < 2; i++) begin
            apply_and_score(1'b1, 1'b0, 16'h0, 6'h0);
            vectors++;
            if (pc_out !== 16'd5 || if_id_pc1 !== 16'd5 || fetch_count !== 16'd5) begin
                miscompares++;
                $display("FAIL stall_hold: got pc=%h pc1=%h cnt=%h required 0005 0005 0005",
                         pc_out, if_id_pc1, fetch_count);
            end
        end
        apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
        vectors++;
        if (pc_out !== 16'd6 || if_id_instr !== 16'h9005) begin
            miscompares++;
            $display("FAIL stall_release: got pc=%h instr=%h required 0006 9005", pc_out, if_id_instr);
        end
    endtask

    task automatic test_branch_back();
        apply_and_score(1'b0, 1'b1, 16'd11, 6'b111010);
        vectors++;
        if (pc_out !== 16'd5 || if_id_instr !== 16'h0000 || if_id_valid !== 1'b0 || if_id_pc1 !== 16'd0) begin
            miscompares++;
            $display("FAIL branch_back: got pc=%h instr=%h valid=%b pc1=%h required 0005 0000 0 0000",
                     pc_out, if_id_instr, if_id_valid, if_id_pc1);
        end
        apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
        vectors++;
        if (if_id_valid !== 1'b1 || if_id_pc1 !== 16'd6 || if_id_instr !== 16'h9005) begin
            miscompares++;
            $display("FAIL branch_refill: got valid=%b pc1=%h instr=%h required 1 0006 9005",
                     if_id_valid, if_id_pc1, if_id_instr);
        end
    endtask

    task automatic test_branch_with_stall();
        apply_and_score(1'b1, 1'b1, 16'd5, 6'd2);
        vectors++;
        if (pc_out !== 16'd7 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) begin
            miscompares++;
            $display("FAIL branch_beats_stall: got pc=%h valid=%b instr=%h required 0007 0 0000",
                     pc_out, if_id_valid, if_id_instr);
        end
        apply_and_score(1'b1, 1'b0, 16'h0, 6'h0);
        apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
    endtask

    task automatic test_wrap();
        apply_and_score(1'b0, 1'b1, 16'hFFFE, 6'd1);
        apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
        vectors++;
        if (pc_out !== 16'h0000 || if_id_pc1 !== 16'h0000 || if_id_instr !== 16'h8FFF || if_id_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pc_wrap: got pc=%h pc1=%h instr=%h valid=%b required 0000 0000 8fff 1",
                     pc_out, if_id_pc1, if_id_instr, if_id_valid);
        end
        apply_and_score(1'b0, 1'b1, 16'd1, 6'b111110);
        vectors++;
        if (pc_out !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL target_wrap: got pc=%h required ffff", pc_out);
        end
    endtask

    task automatic test_back_to_back();
        // alternating advance/stall/branch pattern, scoreboard only
        for (int i = 0; i < 12; i++) begin
            apply_and_score(i % 3 == 1, i % 5 == 4, 16'h0100 + 16'(i), 6'(i * 7));
        end
    endtask

    task automatic test_async_reset();
        test_reset();
        for (int i = 0; i < 9; i++) apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
        vectors++;
        if (pc_out !== 16'd9 || if_id_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_run: got pc=%h valid=%b required 0009 1", pc_out, if_id_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (pc_out !== 16'd0 || if_id_valid !== 1'b0 || fetch_count !== 16'd0 || if_id_pc1 !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset: got pc=%h valid=%b cnt=%h pc1=%h required 0000 0 0000 0000",
                     pc_out, if_id_valid, fetch_count, if_id_pc1);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        apply_and_score(1'b0, 1'b0, 16'h0, 6'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        br_taken    = 1'b0;
        br_base_pc  = 16'h0000;
        br_offset   = 6'h00;
        model_reset();
        test_reset();
        test_free_run();
        test_stall();
        test_branch_back();
        test_branch_with_stall();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
